// File: rtl/legv8_pkg.sv
//============================================================================
// Module      : legv8_pkg
// Description : Shared LEGv8 decode definitions: instruction-format enum,
//               opcode prefix constants/masks, and instruction field bit
//               positions. Also provides the INSTR_LEN define when the
//               common header has not already supplied it.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package legv8_pkg;

  // Format codes; 6 is reserved and never produced.
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_D       = 3'd2,
    FMT_B       = 3'd3,
    FMT_CB      = 3'd4,
    FMT_IW      = 3'd5,
    FMT_UNKNOWN = 3'd7
  } fmt_e;

  // Opcode prefix masks, all expressed on the 11-bit opcode [31:21].
  localparam logic [10:0] c_MASK_B  = 11'b111111_00000;
  localparam logic [10:0] c_MASK_CB = 11'b11111111_000;
  localparam logic [10:0] c_MASK_IW = 11'b111111111_00;
  localparam logic [10:0] c_MASK_I  = 11'b1111111111_0;
  localparam logic [10:0] c_MASK_DR = 11'b11111111111;

  // B-format prefixes ([31:26])
  localparam logic [10:0] c_OP_B     = 11'b000101_00000;
  localparam logic [10:0] c_OP_BL    = 11'b100101_00000;
  // CB-format prefixes ([31:24])
  localparam logic [10:0] c_OP_CBZ   = 11'b10110100_000;
  localparam logic [10:0] c_OP_CBNZ  = 11'b10110101_000;
  localparam logic [10:0] c_OP_BCOND = 11'b01010100_000;
  // IW-format prefixes ([31:23])
  localparam logic [10:0] c_OP_MOVZ  = 11'b110100101_00;
  localparam logic [10:0] c_OP_MOVK  = 11'b111100101_00;
  // I-format prefixes ([31:22])
  localparam logic [10:0] c_OP_ADDI  = 11'b1001000100_0;
  localparam logic [10:0] c_OP_SUBI  = 11'b1101000100_0;
  // D-format opcodes
  localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
  // R-format opcodes
  localparam logic [10:0] c_OP_ADD   = 11'b10001011000;
  localparam logic [10:0] c_OP_SUB   = 11'b11001011000;
  localparam logic [10:0] c_OP_AND   = 11'b10001010000;
  localparam logic [10:0] c_OP_ORR   = 11'b10101010000;
  localparam logic [10:0] c_OP_LSL   = 11'b11010011011;
  localparam logic [10:0] c_OP_LSR   = 11'b11010011010;
  localparam logic [10:0] c_OP_BR    = 11'b11010110000;

  // Field bit positions within the instruction word
  localparam int c_OPCODE_MSB  = 31;
  localparam int c_OPCODE_LSB  = 21;
  localparam int c_ADDR_MSB    = 20;
  localparam int c_ADDR_LSB    = 12;
  localparam int c_RM_MSB      = 20;
  localparam int c_RM_LSB      = 16;
  localparam int c_RN_MSB      = 9;
  localparam int c_RN_LSB      = 5;
  localparam int c_RD_MSB      = 4;
  localparam int c_RD_LSB      = 0;
  localparam int c_SHAMT_MSB   = 15;
  localparam int c_SHAMT_LSB   = 10;
  localparam int c_IMM12_MSB   = 21;
  localparam int c_IMM12_LSB   = 10;
  localparam int c_BR_MSB      = 25;
  localparam int c_BR_LSB      = 0;
  localparam int c_CB_MSB      = 23;
  localparam int c_CB_LSB      = 5;
  localparam int c_MOV_MSB     = 20;
  localparam int c_MOV_LSB     = 5;

endpackage

`default_nettype wire

// File: rtl/instr_fmt_decode.sv
//============================================================================
// Module      : instr_fmt_decode
// Description : Combinational classifier mapping an 11-bit LEGv8 opcode to
//               its instruction format code, with a valid flag for
//               supported opcodes.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_fmt_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  fmt,
  output logic        fmt_valid
);

  logic w_is_b;
  logic w_is_cb;
  logic w_is_iw;
  logic w_is_i;
  logic w_is_d;
  logic w_is_r;

  // Prefix matches; shorter prefixes use masked compares on the opcode.
  assign w_is_b  = ((opcode & c_MASK_B) == c_OP_B) || ((opcode & c_MASK_B) == c_OP_BL);
  assign w_is_cb = ((opcode & c_MASK_CB) == c_OP_CBZ)  ||
                   ((opcode & c_MASK_CB) == c_OP_CBNZ) ||
                   ((opcode & c_MASK_CB) == c_OP_BCOND);
  assign w_is_iw = ((opcode & c_MASK_IW) == c_OP_MOVZ) || ((opcode & c_MASK_IW) == c_OP_MOVK);
  assign w_is_i  = ((opcode & c_MASK_I) == c_OP_ADDI)  || ((opcode & c_MASK_I) == c_OP_SUBI);
  assign w_is_d  = (opcode == c_OP_LDUR) || (opcode == c_OP_STUR);
  assign w_is_r  = (opcode == c_OP_ADD) || (opcode == c_OP_SUB) ||
                   (opcode == c_OP_AND) || (opcode == c_OP_ORR) ||
                   (opcode == c_OP_LSL) || (opcode == c_OP_LSR) ||
                   (opcode == c_OP_BR);

  // Priority select B > CB > IW > I > D > R, anything else is unknown.
  always_comb begin
    fmt       = FMT_UNKNOWN;
    fmt_valid = 1'b1;
    if (w_is_b) begin
      fmt = FMT_B;
    end else if (w_is_cb) begin
      fmt = FMT_CB;
    end else if (w_is_iw) begin
      fmt = FMT_IW;
    end else if (w_is_i) begin
      fmt = FMT_I;
    end else if (w_is_d) begin
      fmt = FMT_D;
    end else if (w_is_r) begin
      fmt = FMT_R;
    end else begin
      fmt       = FMT_UNKNOWN;
      fmt_valid = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_parse.sv
//============================================================================
// Module      : instr_parse
// Description : LEGv8 decode-stage field extractor. Slices the instruction
//               word into all fields unconditionally and classifies its
//               format. Outputs are combinational by default; defining
//               INSTR_PARSE_REG_OUT_EN adds a single output register stage
//               with synchronous active-high reset.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_parse
  import legv8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`INSTR_LEN-1:0] instruction,
  output logic [10:0]           opcode,
  output logic [8:0]            address,
  output logic [4:0]            rm_num,
  output logic [4:0]            rn_num,
  output logic [4:0]            rd_num,
  output logic [5:0]            shamt,
  output logic [11:0]           imm12,
  output logic [25:0]           br_addr,
  output logic [18:0]           cb_addr,
  output logic [15:0]           mov_imm,
  output logic [2:0]            fmt,
  output logic                  fmt_valid
);

  logic [10:0] w_opcode;
  logic [8:0]  w_address;
  logic [4:0]  w_rm_num;
  logic [4:0]  w_rn_num;
  logic [4:0]  w_rd_num;
  logic [5:0]  w_shamt;
  logic [11:0] w_imm12;
  logic [25:0] w_br_addr;
  logic [18:0] w_cb_addr;
  logic [15:0] w_mov_imm;
  logic [2:0]  w_fmt;
  logic        w_fmt_valid;

  // Raw field slices; consumers ignore fields irrelevant to the format.
  assign w_opcode  = instruction[c_OPCODE_MSB:c_OPCODE_LSB];
  assign w_address = instruction[c_ADDR_MSB:c_ADDR_LSB];
  assign w_rm_num  = instruction[c_RM_MSB:c_RM_LSB];
  assign w_rn_num  = instruction[c_RN_MSB:c_RN_LSB];
  assign w_rd_num  = instruction[c_RD_MSB:c_RD_LSB];
  assign w_shamt   = instruction[c_SHAMT_MSB:c_SHAMT_LSB];
  assign w_imm12   = instruction[c_IMM12_MSB:c_IMM12_LSB];
  assign w_br_addr = instruction[c_BR_MSB:c_BR_LSB];
  assign w_cb_addr = instruction[c_CB_MSB:c_CB_LSB];
  assign w_mov_imm = instruction[c_MOV_MSB:c_MOV_LSB];

  instr_fmt_decode u_fmt_decode (
    .opcode    (w_opcode),
    .fmt       (w_fmt),
    .fmt_valid (w_fmt_valid)
  );

`ifdef INSTR_PARSE_REG_OUT_EN
  // Output register stage; reset forces the unknown format and zero fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode    <= '0;
      address   <= '0;
      rm_num    <= '0;
      rn_num    <= '0;
      rd_num    <= '0;
      shamt     <= '0;
      imm12     <= '0;
      br_addr   <= '0;
      cb_addr   <= '0;
      mov_imm   <= '0;
      fmt       <= FMT_UNKNOWN;
      fmt_valid <= 1'b0;
    end else begin
      opcode    <= w_opcode;
      address   <= w_address;
      rm_num    <= w_rm_num;
      rn_num    <= w_rn_num;
      rd_num    <= w_rd_num;
      shamt     <= w_shamt;
      imm12     <= w_imm12;
      br_addr   <= w_br_addr;
      cb_addr   <= w_cb_addr;
      mov_imm   <= w_mov_imm;
      fmt       <= w_fmt;
      fmt_valid <= w_fmt_valid;
    end
  end
`else
  // Clock and reset are kept on the port list but have no function here.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;

  assign opcode    = w_opcode;
  assign address   = w_address;
  assign rm_num    = w_rm_num;
  assign rn_num    = w_rn_num;
  assign rd_num    = w_rd_num;
  assign shamt     = w_shamt;
  assign imm12     = w_imm12;
  assign br_addr   = w_br_addr;
  assign cb_addr   = w_cb_addr;
  assign mov_imm   = w_mov_imm;
  assign fmt       = w_fmt;
  assign fmt_valid = w_fmt_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_parse.sv
//============================================================================
// Module      : tb_instr_parse
// Description : Scoreboard testbench for instr_parse. A stimulus process
//               drives words on the falling edge and queues the expected
//               response from a table-driven reference model; a monitor
//               pops and compares after each rising edge. Works for both
//               the combinational and the INSTR_PARSE_REG_OUT_EN builds.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_parse;

`ifdef INSTR_PARSE_REG_OUT_EN
  localparam bit c_REG = 1'b1;
`else
  localparam bit c_REG = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [`INSTR_LEN-1:0] instruction = '0;
  logic [10:0]           opcode;
  logic [8:0]            address;
  logic [4:0]            rm_num;
  logic [4:0]            rn_num;
  logic [4:0]            rd_num;
  logic [5:0]            shamt;
  logic [11:0]           imm12;
  logic [25:0]           br_addr;
  logic [18:0]           cb_addr;
  logic [15:0]           mov_imm;
  logic [2:0]            fmt;
  logic                  fmt_valid;

  instr_parse dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .opcode      (opcode),
    .address     (address),
    .rm_num      (rm_num),
    .rn_num      (rn_num),
    .rd_num      (rd_num),
    .shamt       (shamt),
    .imm12       (imm12),
    .br_addr     (br_addr),
    .cb_addr     (cb_addr),
    .mov_imm     (mov_imm),
    .fmt         (fmt),
    .fmt_valid   (fmt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    longint      opcode, address, rm, rn, rd, shamt, imm12, br, cb, mov, fmt, fv;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Supported opcode prefixes in priority order: length, value, format.
  int tbl_len[18] = '{6, 6, 8, 8, 8, 9, 9, 10, 10, 11, 11, 11, 11, 11, 11, 11, 11, 11};
  int tbl_val[18] = '{5, 37, 180, 181, 84, 421, 485, 580, 836, 1986, 1984,
                      1112, 1624, 1104, 1360, 1691, 1690, 1712};
  int tbl_fmt[18] = '{3, 3, 4, 4, 4, 5, 5, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0};

  function automatic longint bits(input logic [31:0] w, input int lo, input int n);
    longint v;
    v = longint'(w);
    return (v >> lo) % (longint'(1) << n);
  endfunction

  function automatic exp_t model(input logic [31:0] w, input bit in_rst);
    exp_t e;
    e.word = w;
    if (c_REG && in_rst) begin
      e.opcode = 0; e.address = 0; e.rm = 0; e.rn = 0; e.rd = 0; e.shamt = 0;
      e.imm12 = 0; e.br = 0; e.cb = 0; e.mov = 0; e.fmt = 7; e.fv = 0;
      return e;
    end
    e.opcode  = bits(w, 21, 11);
    e.address = bits(w, 12, 9);
    e.rm      = bits(w, 16, 5);
    e.rn      = bits(w, 5, 5);
    e.rd      = bits(w, 0, 5);
    e.shamt   = bits(w, 10, 6);
    e.imm12   = bits(w, 10, 12);
    e.br      = bits(w, 0, 26);
    e.cb      = bits(w, 5, 19);
    e.mov     = bits(w, 5, 16);
    e.fmt     = 7;
    e.fv      = 0;
    for (int k = 0; k < 18; k++) begin
      if (e.fv == 0 && bits(w, 32 - tbl_len[k], tbl_len[k]) == longint'(tbl_val[k])) begin
        e.fmt = tbl_fmt[k];
        e.fv  = 1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] word, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: instr=%h got %0d expected %0d", name, word, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] w, input bit r);
    @(negedge clk);
    rst         = r;
    instruction = w;
    q.push_back(model(w, r));
  endtask

  function automatic logic [31:0] rand_word();
    int k;
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, 17);
      w = (w >> tbl_len[k]) | (32'(tbl_val[k]) << (32 - tbl_len[k]));
    end
    return w;
  endfunction

  // Monitor: one queued expectation is checked after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if ($isunknown({opcode, address, rm_num, rn_num, rd_num, shamt, imm12,
                        br_addr, cb_addr, mov_imm, fmt, fmt_valid}))
          chk("x_free", e.word, 1, 0);
        chk("opcode",    e.word, longint'(opcode),    e.opcode);
        chk("address",   e.word, longint'(address),   e.address);
        chk("rm_num",    e.word, longint'(rm_num),    e.rm);
        chk("rn_num",    e.word, longint'(rn_num),    e.rn);
        chk("rd_num",    e.word, longint'(rd_num),    e.rd);
        chk("shamt",     e.word, longint'(shamt),     e.shamt);
        chk("imm12",     e.word, longint'(imm12),     e.imm12);
        chk("br_addr",   e.word, longint'(br_addr),   e.br);
        chk("cb_addr",   e.word, longint'(cb_addr),   e.cb);
        chk("mov_imm",   e.word, longint'(mov_imm),   e.mov);
        chk("fmt",       e.word, longint'(fmt),       e.fmt);
        chk("fmt_valid", e.word, longint'(fmt_valid), e.fv);
      end
    end
  end

  // Stimulus: reset, directed words, mid-stream reset, then random words.
  initial begin
    logic [31:0] dir[8];
    dir = '{32'hF84F02C9, 32'h8B0902AA, 32'hF80402EA, 32'h14000003,
            32'hB4000041, 32'h00000000, 32'hD2800000, 32'h91000421};

    drive(32'h8B0902AA, 1'b1);
    drive(32'hB4000041, 1'b1);
    drive(32'hF84F02C9, 1'b0);
    drive(32'h14000003, 1'b1);
    foreach (dir[i]) drive(dir[i], 1'b0);
    drive(32'hFFFFFFFF, 1'b0);

    for (int n = 0; n < 400; n++) begin
      drive(rand_word(), ($urandom_range(0, 19) == 0));
    end

    drive(32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'h0, longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
